// File: rtl/cordic_iter_unload.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_iter_unload
//  Description : Sequences one CORDIC computation (mux select and iteration
//                index), then captures the loop register into an output FIFO
//                that is drained with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter_unload #(
    parameter int WIDTH = 6,
    parameter int ITERS = 8,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       start,
    output logic                       start_ready,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           loop_in,
    output logic                       sel_init,
    output logic [$clog2(ITERS)-1:0]   iter,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW = $clog2(ITERS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [IW-1:0] c_ITER_LAST = IW'(ITERS - 1);
    localparam logic [CW-1:0] c_DEPTH     = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_iter;
    logic [IW-1:0]      w_iter_nxt;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_start_ready;
    logic               w_push;
    logic               w_pop;

    // Sequencer state register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    // A start only reserves a FIFO slot when one is free, so CAPTURE can
    // always push without an overflow check.
    assign w_start_ready = (r_state == S_IDLE) && (r_count < c_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        case (r_state)
            S_IDLE: begin
                w_iter_nxt = '0;
                if (start && w_start_ready) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_iter_nxt  = '0;
                end else if (r_iter == c_ITER_LAST) begin
                    w_state_nxt = S_CAPTURE;
                    w_iter_nxt  = '0;
                end else begin
                    w_iter_nxt  = r_iter + 1'b1;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_IDLE;
                w_iter_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_iter_nxt  = '0;
            end
        endcase
    end

    assign w_push = (r_state == S_CAPTURE) && !abort;
    assign w_pop  = (r_count != '0) && out_ready;

    // Output FIFO; storage is cleared on reset so out_data reads zero after it
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= loop_in;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign start_ready = w_start_ready;
    assign sel_init    = (r_state == S_RUN) && (r_iter == '0);
    assign iter        = r_iter;
    assign busy        = (r_state == S_RUN) || (r_state == S_CAPTURE);
    assign done        = w_push;
    assign out_data    = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_unload.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_iter_unload
//  Description : Self-checking bench; directed scenarios plus random traffic
//                compared each cycle against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_iter_unload;

    localparam int WIDTH = 6;
    localparam int ITERS = 8;
    localparam int DEPTH = 2;

    logic               CLK = 1'b0;
    logic               RSTn;
    logic               start;
    logic               start_ready;
    logic               abort;
    logic [WIDTH-1:0]   loop_in;
    logic               sel_init;
    logic [2:0]         iter;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase = cycles since the start was accepted
    // (1..ITERS are iterations, ITERS+1 is the capture cycle).
    bit m_known  = 0;
    bit m_active = 0;
    int m_phase  = 0;
    int m_q[$];

    cordic_iter_unload #(.WIDTH(WIDTH), .ITERS(ITERS), .DEPTH(DEPTH)) u_dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .start_ready (start_ready),
        .abort       (abort),
        .loop_in     (loop_in),
        .sel_init    (sel_init),
        .iter        (iter),
        .busy        (busy),
        .done        (done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_model(input logic a);
        int exp_iter;
        exp_iter = (m_active && m_phase <= ITERS) ? m_phase - 1 : 0;
        check("busy",        32'(busy),        32'(m_active));
        check("sel_init",    32'(sel_init),    32'(m_active && m_phase == 1));
        check("iter",        32'(iter),        32'(exp_iter));
        check("done",        32'(done),        32'(m_active && m_phase == ITERS + 1 && !a));
        check("count",       32'(count),       32'(m_q.size()));
        check("out_valid",   32'(out_valid),   32'(m_q.size() > 0));
        check("start_ready", 32'(start_ready), 32'(!m_active && m_q.size() < DEPTH));
        if (m_q.size() > 0) check("out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    task automatic model_edge(input logic s, input logic a, input logic r,
                              input logic [WIDTH-1:0] d, input logic rn);
        bit sr;
        if (!rn) begin
            m_active = 0;
            m_phase  = 0;
            m_q.delete();
            m_known  = 1;
            return;
        end
        sr = !m_active && m_q.size() < DEPTH;
        if (m_q.size() > 0 && r) void'(m_q.pop_front());
        if (m_active) begin
            if (a) begin
                m_active = 0;
            end else if (m_phase == ITERS + 1) begin
                m_q.push_back(int'(d));
                m_active = 0;
            end else begin
                m_phase++;
            end
        end else if (s && sr) begin
            m_active = 1;
            m_phase  = 1;
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge
    task automatic step(input logic s, input logic a, input logic r,
                        input logic [WIDTH-1:0] d, input logic rn);
        start = s; abort = a; out_ready = r; loop_in = d; RSTn = rn;
        @(negedge CLK);
        if (m_known) check_model(a);
        @(posedge CLK);
        model_edge(s, a, r, d, rn);
        #1;
    endtask

    // Full computation: start cycle, ITERS run cycles, then capture cycle
    task automatic run_comp(input logic [WIDTH-1:0] d, input logic rdy_at_cap);
        step(1, 0, 0, d, 1);
        repeat (ITERS) step(0, 0, 0, d, 1);
        step(0, 0, rdy_at_cap, d, 1);
    endtask

    initial begin
        start = 0; abort = 0; out_ready = 0; loop_in = '0; RSTn = 0;
        repeat (2) step(0, 0, 0, '0, 0);
        check("rst_data",  32'(out_data),    32'h0);
        check("rst_ready", 32'(start_ready), 32'h1);

        // Single computation, latency ITERS+2 to valid
        step(1, 0, 0, '0, 1);
        check("t1_sel_init", 32'(sel_init), 32'h1);
        for (int k = 1; k <= ITERS + 1; k++) step(0, 0, 0, 6'h2A, 1);
        check("t10_valid", 32'(out_valid), 32'h1);
        check("t10_data",  32'(out_data),  32'h2A);
        step(0, 0, 1, '0, 1);

        // Fill FIFO, third start ignored, drain in order
        run_comp(6'h05, 0);
        run_comp(6'h3F, 0);
        check("full_count", 32'(count),       32'h2);
        check("full_ready", 32'(start_ready), 32'h0);
        step(1, 0, 0, '0, 1);
        check("full_nostart", 32'(busy), 32'h0);
        check("pop0", 32'(out_data), 32'h05);
        step(0, 0, 1, '0, 1);
        check("pop1", 32'(out_data), 32'h3F);
        step(0, 0, 1, '0, 1);
        check("drained", 32'(count), 32'h0);

        // Push and pop in the same cycle
        run_comp(6'h11, 0);
        run_comp(6'h22, 1);
        check("pp_count", 32'(count),    32'h1);
        check("pp_data",  32'(out_data), 32'h22);
        step(0, 0, 1, '0, 1);

        // Abort at iter 4, then a full computation
        step(1, 0, 0, '0, 1);
        repeat (4) step(0, 0, 0, '0, 1);
        check("abort_iter", 32'(iter), 32'h4);
        step(0, 1, 0, 6'h0F, 1);
        check("abort_idle", 32'(busy), 32'h0);
        run_comp(6'h19, 0);
        check("after_abort", 32'(out_data), 32'h19);

        // Reset mid-run with one entry held
        step(1, 0, 0, '0, 1);
        repeat (3) step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_busy",  32'(busy),      32'h0);
        check("mrst_data",  32'(out_data),  32'h0);

        // start+abort in IDLE, pop when empty
        step(1, 1, 1, '0, 1);
        check("sa_busy", 32'(busy),  32'h1);
        check("sa_cnt",  32'(count), 32'h0);
        repeat (ITERS + 1) step(0, 0, 0, 6'h2B, 1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, WIDTH'($urandom),
                 $urandom_range(0, 149) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
